// File: rtl/mem_bus_arb.sv
// mem_bus_arb: arbitrates the IF and MEM ports of the CPU onto one registered
// request/acknowledge memory bus, with fixed MEM priority and a wait timeout.
module mem_bus_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  localparam int unsigned   CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);
  localparam logic          TMO_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic          discard_r, discard_s, discard_now_s, timeout_s;
  logic          bus_req_r, bus_req_s, bus_we_r, bus_we_s;
  logic [3:0]    bus_sel_r, bus_sel_s;
  logic [31:0]   bus_addr_r, bus_addr_s, bus_wdata_r, bus_wdata_s;
  logic [31:0]   if_rdata_r, if_rdata_s, mem_rdata_r, mem_rdata_s;
  logic          if_ready_r, if_ready_s, mem_ready_r, mem_ready_s;
  logic          bus_err_r, bus_err_s;

  assign cnt_inc_s     = cnt_r + CW'(1);
  assign timeout_s     = TMO_EN && (cnt_inc_s == TMO_VAL);
  // A flush arriving in the same cycle as the ack still discards the fetch.
  assign discard_now_s = discard_r | flush;

  // Next-state and next-register computation for the arbiter FSM.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    discard_s   = discard_r;
    bus_req_s   = bus_req_r;
    bus_we_s    = bus_we_r;
    bus_sel_s   = bus_sel_r;
    bus_addr_s  = bus_addr_r;
    bus_wdata_s = bus_wdata_r;
    if_rdata_s  = if_rdata_r;
    mem_rdata_s = mem_rdata_r;
    if_ready_s  = 1'b0;
    mem_ready_s = 1'b0;
    bus_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s     = '0;
        discard_s = 1'b0;
        if (mem_req) begin
          bus_req_s   = 1'b1;
          bus_we_s    = mem_we;
          bus_sel_s   = mem_sel;
          bus_addr_s  = mem_addr;
          bus_wdata_s = mem_wdata;
          state_s     = MEM_BUSY;
        end else if (if_req && !flush) begin
          bus_req_s   = 1'b1;
          bus_we_s    = 1'b0;
          bus_sel_s   = 4'hF;
          bus_addr_s  = if_addr;
          bus_wdata_s = 32'h0000_0000;
          state_s     = IF_BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      IF_BUSY: begin
        discard_s = discard_now_s;
        if (bus_ack) begin
          bus_req_s = 1'b0;
          state_s   = DONE;
          if (!discard_now_s) begin
            if_rdata_s = bus_rdata;
            if_ready_s = 1'b1;
          end else begin
            if_rdata_s = if_rdata_r;
          end
        end else if (timeout_s) begin
          bus_req_s = 1'b0;
          state_s   = DONE;
          if (!discard_now_s) begin
            if_rdata_s = 32'h0000_0000;
            if_ready_s = 1'b1;
            bus_err_s  = 1'b1;
          end else begin
            if_rdata_s = if_rdata_r;
          end
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      MEM_BUSY: begin
        if (bus_ack) begin
          bus_req_s   = 1'b0;
          state_s     = DONE;
          mem_rdata_s = bus_we_r ? 32'h0000_0000 : bus_rdata;
          mem_ready_s = 1'b1;
        end else if (timeout_s) begin
          bus_req_s   = 1'b0;
          state_s     = DONE;
          mem_rdata_s = 32'h0000_0000;
          mem_ready_s = 1'b1;
          bus_err_s   = 1'b1;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      DONE: begin
        // No grant here, so a still-high req from the finished owner is not re-served.
        state_s   = IDLE;
        cnt_s     = '0;
        discard_s = 1'b0;
      end
      default: begin
        state_s   = IDLE;
        cnt_s     = '0;
        discard_s = 1'b0;
        bus_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      discard_r   <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_sel_r   <= 4'h0;
      bus_addr_r  <= 32'h0000_0000;
      bus_wdata_r <= 32'h0000_0000;
      if_rdata_r  <= 32'h0000_0000;
      mem_rdata_r <= 32'h0000_0000;
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
      bus_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      discard_r   <= discard_s;
      bus_req_r   <= bus_req_s;
      bus_we_r    <= bus_we_s;
      bus_sel_r   <= bus_sel_s;
      bus_addr_r  <= bus_addr_s;
      bus_wdata_r <= bus_wdata_s;
      if_rdata_r  <= if_rdata_s;
      mem_rdata_r <= mem_rdata_s;
      if_ready_r  <= if_ready_s;
      mem_ready_r <= mem_ready_s;
      bus_err_r   <= bus_err_s;
    end
  end

  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_sel   = bus_sel_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign if_rdata  = if_rdata_r;
  assign mem_rdata = mem_rdata_r;
  assign if_ready  = if_ready_r;
  assign mem_ready = mem_ready_r;
  assign bus_err   = bus_err_r;

  assign stallreq_mem = mem_req & ~mem_ready_r;
  assign stallreq_if  = if_req & ~if_ready_r & ~flush;

endmodule

// File: doc/mem_bus_arb.md
# mem_bus_arb

Arbiter and sequencer for the single shared external memory bus of the 5-stage CPU. It serves two requesters: the instruction-fetch port (IF stage) and the load/store port (MEM stage, fed by the EX/MEM pipeline register). Each transfer runs as a registered request/acknowledge transaction. While a requester is waiting, the block raises that requester's stall request to the pipeline controller, which folds it into `stall[5:0]`.

## Interface
- `TIMEOUT`, 255: maximum bus cycles to wait for `bus_ack`; 0 disables the timeout.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  IF read request; held until `if_ready`.
- `if_addr`  in  32  fetch address.
- `if_rdata`  out  32  fetched word.
- `if_ready`  out  1  one-cycle completion pulse for IF.
- `mem_req`  in  1  MEM request; held until `mem_ready`.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_sel`  in  4  byte enables.
- `mem_addr`  in  32  data address.
- `mem_wdata`  in  32  store data.
- `mem_rdata`  out  32  load data.
- `mem_ready`  out  1  one-cycle completion pulse for MEM.
- `flush`  in  1  pipeline flush; discards the IF fetch.
- `bus_req`, `bus_we`  out  1 each  registered bus strobe and direction.
- `bus_sel`  out  4  registered bus byte enables.
- `bus_addr`, `bus_wdata`  out  32 each  registered bus address and write data.
- `bus_rdata`  in  32  bus read data, valid with `bus_ack`.
- `bus_ack`  in  1  bus completion.
- `bus_err`  out  1  timeout flag; pulses together with the ready pulse.
- `stallreq_if`, `stallreq_mem`  out  1 each  stall requests to the pipeline controller.

## Operation
- States: `IDLE`, `IF_BUSY`, `MEM_BUSY`, `DONE`.
- IDLE grant:
  - If `mem_req` is asserted, latch `mem_addr`, `mem_we`, `mem_sel` and `mem_wdata` onto the `bus_*` registers, set `bus_req`, and go to MEM_BUSY.
  - Otherwise, if `if_req` is asserted and `flush` is not, latch `if_addr` with we=0 and sel=4'hF, set `bus_req`, and go to IF_BUSY.
  - MEM has fixed priority because it is the older instruction. There is no preemption.
- BUSY:
  - The bus registers stay frozen.
  - A wait counter increments each cycle.
  - On `bus_ack`:
    - Clear `bus_req`.
    - For a read, capture `bus_rdata` into the owner's rdata register. For a write, load 0 into `mem_rdata`.
    - Set the owner's ready pulse for the next cycle and go to DONE.
- Timeout: if `TIMEOUT` is nonzero and the counter reaches `TIMEOUT` without an ack:
  - Clear `bus_req`.
  - Set the owner's rdata to 0 and assert ready and `bus_err`.
  - Go to DONE.
- DONE: ready and `bus_err` are high for this cycle only. The block makes no grant in DONE, so the requester's still-high `req` is not re-served. Next state is IDLE.
- Stall requests:
  - `stallreq_mem = mem_req & ~mem_ready`
  - `stallreq_if = if_req & ~if_ready & ~flush`
  - Both are combinational from inputs and registered ready.
- Flush:
  - In IF_BUSY, `flush` sets a discard flag. The transfer still completes on the bus, but `if_ready` is suppressed and `if_rdata` is unchanged.
  - In IDLE, `flush` blocks an IF grant for that cycle.
  - A MEM transfer is never affected by `flush`.
- Reset (asynchronous, any state):
  - All outputs go to 0: bus registers, rdata registers, ready signals and `bus_err`.
  - The FSM returns to IDLE; the counter and discard flag clear.
  - `bus_req` falls immediately and an in-flight transaction is abandoned.

## Timing
- Requests are sampled in IDLE at edge t.
- `bus_*` is valid from t+1.
- An ack in cycle t+k (k≥1) gives ready and data valid in cycle t+k+1 (DONE); the FSM is back in IDLE at t+k+2.
- Minimum turnaround is 3 cycles per transfer, with 1 dead cycle between back-to-back transfers.
- `bus_ack` is ignored outside the BUSY states.
- Simultaneous `if_req` and `mem_req`: MEM is served first. IF is granted in the IDLE cycle after MEM's DONE, if still requested.

## Test plan
- Reset: drive `rst`=0 mid-transfer in MEM_BUSY with `bus_req`=1 → `bus_req`, ready signals and data all 0 immediately (asynchronously); FSM in IDLE after release.
- IF fetch: `if_req`=1, `if_addr`=0x0000_0040, ack with `bus_rdata`=0x3C01_1234 in the first bus cycle → `if_ready` one cycle at t+2, `if_rdata`=0x3C01_1234, `stallreq_if` high t..t+1 and low at t+2.
- Contention: `if_req` and `mem_req` (load from 0x100, ack data 0xDEAD_BEEF) raised together → MEM transfer first, `mem_rdata`=0xDEAD_BEEF; IF `bus_req` rises 2 cycles after `mem_ready`.
- Store: `mem_we`=1, `mem_sel`=4'b0011, `mem_wdata`=0x0000_ABCD, ack after 4 cycles → `bus_*` frozen for all 4 cycles, `mem_ready` pulse, `mem_rdata`=0.
- Timeout: `TIMEOUT`=8 with no ack → `bus_req` drops after 8 busy cycles; `mem_ready` and `bus_err` pulse together; `mem_rdata`=0.
- Flush: assert `flush` during IF_BUSY, then ack → no `if_ready`, `if_rdata` unchanged, FSM returns to IDLE via DONE.
